// File: rtl/accel_bus_initiator_if.sv
// Command, response and peripheral-register signals of the accelerator bus initiator.
// The master modport is the initiator's view; slave is the host link plus peripheral side.
interface accel_bus_initiator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] bus_address;
    logic       bus_data_write;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;

    modport master (
        input  cmd_valid,
        input  cmd_data,
        input  rsp_ready,
        input  bus_data_out,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output bus_address,
        output bus_data_write,
        output bus_data_in
    );

    modport slave (
        output cmd_valid,
        output cmd_data,
        output rsp_ready,
        output bus_data_out,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  bus_address,
        input  bus_data_write,
        input  bus_data_in
    );
endinterface

// File: rtl/accel_bus_initiator.sv
// Turns a byte command stream into single-cycle register writes and timed register reads on the
// 4-bit-address / 8-bit-data peripheral bus, returning read bytes on a valid/ready response stream.
module accel_bus_initiator #(
    parameter int unsigned READ_WAIT = 1,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         abort_i,
    output logic                         busy_o,
    accel_bus_initiator_if.master        bus_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WSTROBE,
        S_RWAIT,
        S_RRESP
    } state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

    state_e     state_q;
    logic [3:0] addr_q;
    logic [3:0] beats_q;
    logic [3:0] wait_q;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    logic       cmd_fire;
    logic       rsp_fire;
    logic       last_beat;
    logic [3:0] step_addr;

    // Header and write-data bytes are only taken in IDLE/WDATA, never while abort or reset is asserted.
    assign bus_if.cmd_ready = rst_n && !abort_i && (state_q == S_IDLE || state_q == S_WDATA);
    assign busy_o           = (state_q != S_IDLE);

    assign cmd_fire  = bus_if.cmd_valid && bus_if.cmd_ready;
    assign rsp_fire  = rsp_valid_q && bus_if.rsp_ready;
    assign last_beat = (beats_q == 4'd1);
    assign step_addr = AUTO_INC ? addr_q + 4'd1 : addr_q;

    assign bus_if.bus_address    = addr_q;
    assign bus_if.bus_data_write = wr_q;
    assign bus_if.bus_data_in    = wdata_q;
    assign bus_if.rsp_valid      = rsp_valid_q;
    assign bus_if.rsp_data       = rsp_data_q;

    // NOTE: every register here is updated with <= so all branches see the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            beats_q     <= '0;
            wait_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (abort_i) begin
            // Address and last read byte are left as they were; only the transaction is dropped.
            state_q     <= S_IDLE;
            beats_q     <= '0;
            wait_q      <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= bus_if.cmd_data[3:0];
                        beats_q <= {1'b0, bus_if.cmd_data[6:4]} + 4'd1;
                        wait_q  <= WAIT_LOAD;
                        state_q <= bus_if.cmd_data[7] ? S_WDATA : S_RWAIT;
                    end
                end
                S_WDATA: begin
                    if (cmd_fire) begin
                        wdata_q <= bus_if.cmd_data;
                        wr_q    <= 1'b1;
                        state_q <= S_WSTROBE;
                    end
                end
                S_WSTROBE: begin
                    // Address moves only after the strobe drops, so it is stable for the whole write cycle.
                    addr_q  <= step_addr;
                    beats_q <= beats_q - 4'd1;
                    state_q <= last_beat ? S_IDLE : S_WDATA;
                end
                S_RWAIT: begin
                    if (wait_q <= 4'd1) begin
                        rsp_data_q  <= bus_if.bus_data_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RRESP;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_RRESP: begin
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        addr_q      <= step_addr;
                        beats_q     <= beats_q - 4'd1;
                        wait_q      <= WAIT_LOAD;
                        state_q     <= last_beat ? S_IDLE : S_RWAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
